// File: rtl/lap_timer_pkg.sv
// Shared types and constants for the lap timer: FSM encoding, BCD digit
// geometry, digit limits and the load-value validity check.
package lap_timer_pkg;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DIGIT_W    = 4;
    localparam int TIME_W     = 24;
    localparam int NUM_DIGITS = TIME_W / DIGIT_W;

    // Tens-of-minutes/seconds roll at 5, every other digit at 9.
    localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;
    localparam logic [DIGIT_W-1:0] UNITS_MAX = 4'd9;

    // True when t is a legal packed BCD time {hh, mm, ss} with hh <= hr_max.
    function automatic logic bcd_time_valid(input logic [TIME_W-1:0] t, input int hr_max);
        logic ok;
        int   hrs;
        ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[i*DIGIT_W +: DIGIT_W] > UNITS_MAX) ok = 1'b0;
        end
        if (t[7:4]   > TENS_MAX) ok = 1'b0;
        if (t[15:12] > TENS_MAX) ok = 1'b0;
        hrs = 10 * int'(t[23:20]) + int'(t[19:16]);
        if (hrs > hr_max) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/lap_timer_if.sv
// Control/status bundle of the lap timer. The master side drives the
// buttons and load path; the slave side (the timer) returns time and flags.
interface lap_timer_if;
    import lap_timer_pkg::*;

    logic              start_stop;
    logic              clear;
    logic              lap;
    logic              dir;
    logic              load;
    logic [TIME_W-1:0] load_val;
    logic [TIME_W-1:0] time_out;
    logic [TIME_W-1:0] lap_out;
    logic              lap_valid;
    logic              running;
    logic              expired;
    logic              wrap;

    modport master (
        output start_stop, clear, lap, dir, load, load_val,
        input  time_out, lap_out, lap_valid, running, expired, wrap
    );

    modport slave (
        input  start_stop, clear, lap, dir, load, load_val,
        output time_out, lap_out, lap_valid, running, expired, wrap
    );

endinterface

// File: rtl/lap_timer_bcd_digit.sv
// One up/down BCD digit rolling between 0 and MAX. Clear beats load beats
// count; co_o flags that this enabled step rolls over (up) or borrows (down).
module bcd_digit
    import lap_timer_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAX = UNITS_MAX
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr_i,
    input  logic               ld_i,
    input  logic [DIGIT_W-1:0] ld_val_i,
    input  logic               en_i,
    input  logic               dir_i,
    output logic [DIGIT_W-1:0] q_o,
    output logic               co_o
);

    logic [DIGIT_W-1:0] q_q, q_d;

    // Next digit value: clear, then load, then one count step when enabled.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (ld_i) begin
            q_d = ld_val_i;
        end else if (en_i) begin
            if (dir_i) q_d = (q_q == '0)  ? MAX : q_q - 4'd1;
            else       q_d = (q_q == MAX) ? '0  : q_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o  = q_q;
    assign co_o = en_i & (dir_i ? (q_q == '0) : (q_q == MAX));

endmodule

// File: rtl/lap_timer.sv
// Stopwatch / countdown timer in packed BCD hh:mm:ss with split capture.
// Button inputs are edge-detected; the time is a ripple chain of BCD digits
// advanced by a prescaled tick while running.
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int HR_MAX   = 99
) (
    input  logic        clk,
    input  logic        rstn,
    lap_timer_if.slave  tmr
);

    localparam int                PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]        HR_MAX_BCD = 8'(((HR_MAX / 10) << 4) | (HR_MAX % 10));
    localparam logic [TIME_W-1:0] TIME_MAX   = {HR_MAX_BCD, 16'h5959};

    // Button edge detect: bit 0 start_stop, bit 1 clear, bit 2 lap.
    logic [2:0] btn_raw, s0_q, s1_q, btn_edge;
    logic       start_e, clr_e, lap_e;

    state_e            state_q, state_d;
    logic              dir_q;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TIME_W-1:0] time_w;
    logic [TIME_W-1:0] lap_q;
    logic              lap_valid_q;
    logic              wrap_q;

    logic tick, load_ok, run_go, up_wrap, down_done;
    logic [NUM_DIGITS-1:0] en_w;
    logic top_carry_unused;

    assign btn_raw  = {tmr.lap, tmr.clear, tmr.start_stop};
    assign btn_edge = ~s1_q & s0_q;
    assign start_e  = btn_edge[0];
    assign clr_e    = btn_edge[1];
    assign lap_e    = btn_edge[2];

    // Two-flop shift per button; an edge is a fresh 0->1 in the pair.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_q <= '0;
            s1_q <= '0;
        end else begin
            s0_q <= btn_raw;
            s1_q <= s0_q;
        end
    end

    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
    assign load_ok   = tmr.load && !clr_e && (state_q != ST_RUN)
                       && bcd_time_valid(tmr.load_val, HR_MAX);
    // A countdown from zero would expire immediately, so that start is ignored.
    assign run_go    = start_e && !clr_e && !load_ok && (state_q == ST_STOP)
                       && !(tmr.dir && (time_w == '0));
    assign up_wrap   = tick && !dir_q && (time_w == TIME_MAX);
    assign down_done = tick && dir_q && (time_w == TIME_W'(1));

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_STOP;
        else       state_q <= state_d;
    end

    // FSM next state: clear, then load, then start toggle, then countdown expiry.
    always_comb begin
        state_d = state_q;
        if (clr_e || load_ok) begin
            state_d = ST_STOP;
        end else if (start_e) begin
            case (state_q)
                ST_STOP: if (run_go) state_d = ST_RUN;
                ST_RUN:  state_d = ST_STOP;
                default: state_d = ST_STOP;
            endcase
        end else if (down_done) begin
            state_d = ST_DONE;
        end
    end

    // FSM outputs decoded from the registered state.
    always_comb begin
        tmr.running = (state_q == ST_RUN);
        tmr.expired = (state_q == ST_DONE);
    end

    // Count direction is frozen for the whole run at the moment it starts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       dir_q <= 1'b0;
        else if (run_go) dir_q <= tmr.dir;
    end

    // Prescaler: advances only while running, zeroed by clear or load.
    always_comb begin
        presc_d = presc_q;
        if (clr_e || load_ok)       presc_d = '0;
        else if (state_q == ST_RUN) presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    // Digit chain, seconds units first. The hour limit spans two digits, so
    // the full-scale rollover is a top-level clear rather than a digit carry.
    assign en_w[0] = tick;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        logic [DIGIT_W-1:0] q_w;
        logic               co_w;

        bcd_digit #(
            .MAX ((g == 1 || g == 3) ? TENS_MAX : UNITS_MAX)
        ) u_digit (
            .clk      (clk),
            .rstn     (rstn),
            .clr_i    (clr_e | up_wrap),
            .ld_i     (load_ok),
            .ld_val_i (tmr.load_val[g*DIGIT_W +: DIGIT_W]),
            .en_i     (en_w[g]),
            .dir_i    (dir_q),
            .q_o      (q_w),
            .co_o     (co_w)
        );

        assign time_w[g*DIGIT_W +: DIGIT_W] = q_w;

        if (g < NUM_DIGITS - 1) begin : g_carry
            assign en_w[g+1] = co_w;
        end else begin : g_top
            assign top_carry_unused = co_w;
        end
    end

    // Split capture takes the registered (pre-tick) time; clear drops it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lap_q       <= '0;
            lap_valid_q <= 1'b0;
        end else if (clr_e) begin
            lap_valid_q <= 1'b0;
        end else if (lap_e) begin
            lap_q       <= time_w;
            lap_valid_q <= 1'b1;
        end
    end

    // Single-cycle rollover pulse for up counts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wrap_q <= 1'b0;
        else       wrap_q <= up_wrap && !clr_e;
    end

    assign tmr.time_out  = time_w;
    assign tmr.lap_out   = lap_q;
    assign tmr.lap_valid = lap_valid_q;
    assign tmr.wrap      = wrap_q;

endmodule

// File: tb/tb_lap_timer.sv
// Directed bench for lap_timer. Main DUT: TICK_DIV=4, HR_MAX=23. A second
// instance with default parameters shares the inputs for the TICK_DIV=1 case.
module tb_lap_timer;
    import lap_timer_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    lap_timer_if ifa ();
    lap_timer_if ifb ();

    lap_timer #(.TICK_DIV(4), .HR_MAX(23)) dut (
        .clk  (clk),
        .rstn (rstn),
        .tmr  (ifa.slave)
    );

    lap_timer dut1 (
        .clk  (clk),
        .rstn (rstn),
        .tmr  (ifb.slave)
    );

    assign ifb.start_stop = ifa.start_stop;
    assign ifb.clear      = ifa.clear;
    assign ifb.lap        = ifa.lap;
    assign ifb.dir        = ifa.dir;
    assign ifb.load       = ifa.load;
    assign ifb.load_val   = ifa.load_val;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ifa.start_stop = 1'b1;
        step(1);
        ifa.start_stop = 1'b0;
    endtask

    task automatic do_load(input logic [23:0] v);
        ifa.load     = 1'b1;
        ifa.load_val = v;
        step(1);
        ifa.load     = 1'b0;
    endtask

    function automatic logic [23:0] flags();
        return {20'd0, ifa.lap_valid, ifa.running, ifa.expired, ifa.wrap};
    endfunction

    logic [23:0] bad_loads [4];

    initial begin
        bad_loads = '{24'h006000, 24'h240000, 24'h000060, 24'h00000A};
        rstn = 1'b0;
        ifa.start_stop = 1'b0; ifa.clear = 1'b0; ifa.lap = 1'b0;
        ifa.dir = 1'b0; ifa.load = 1'b0; ifa.load_val = '0;
        step(2);
        chk("rst_time",  ifa.time_out, 24'h0);
        chk("rst_lap",   ifa.lap_out,  24'h0);
        chk("rst_flags", flags(),      24'h0);
        rstn = 1'b1;
        step(1);

        // Up count, TICK_DIV=4: tick every 4th RUN cycle.
        pulse_start();
        step(40);
        chk("up_39cyc", ifa.time_out, 24'h000009);
        step(1);
        chk("up_40cyc",     ifa.time_out, 24'h000010);
        chk("up_running",   {23'd0, ifa.running}, 24'h1);
        chk("div1_40cyc",   ifb.time_out, 24'h000040);

        // Hour rollover at 23:59:59.
        pulse_start();
        step(2);
        do_load(24'h235959);
        chk("ld_235959", ifa.time_out, 24'h235959);
        pulse_start();
        step(4);
        chk("pre_wrap_time", ifa.time_out, 24'h235959);
        chk("pre_wrap_flag", {23'd0, ifa.wrap}, 24'h0);
        step(1);
        chk("wrap_time", ifa.time_out, 24'h000000);
        chk("wrap_flag", flags(), 24'h4 | 24'h1);
        step(1);
        chk("wrap_1cyc", {23'd0, ifa.wrap}, 24'h0);

        // Loads: ignored in RUN, rejected when invalid, accepted in STOP.
        do_load(24'h123456);
        chk("ld_in_run", ifa.time_out, 24'h000000);
        step(1);
        pulse_start();
        step(1);
        chk("stopped_time", ifa.time_out, 24'h000001);
        chk("stopped_run",  {23'd0, ifa.running}, 24'h0);
        for (int i = 0; i < 4; i++) begin
            do_load(bad_loads[i]);
            chk($sformatf("bad_ld_%0d", i), ifa.time_out, 24'h000001);
        end
        do_load(24'h123456);
        chk("ld_stop", ifa.time_out, 24'h123456);

        // Countdown to DONE, restart blocked at zero.
        do_load(24'h000002);
        ifa.dir = 1'b1;
        pulse_start();
        step(5);
        chk("dn_1", ifa.time_out, 24'h000001);
        chk("dn_1_run", {23'd0, ifa.running}, 24'h1);
        step(4);
        chk("dn_0", ifa.time_out, 24'h000000);
        chk("dn_done", flags(), 24'h2);
        step(3);
        chk("done_hold", flags(), 24'h2);
        pulse_start();
        step(1);
        chk("done_to_stop", flags(), 24'h0);
        pulse_start();
        step(2);
        chk("zero_dn_start", flags(), 24'h0);
        ifa.dir = 1'b0;

        // Lap capture, then clear+start+lap together while running.
        do_load(24'h000500);
        pulse_start();
        step(5);
        chk("lap_pre", ifa.time_out, 24'h000501);
        ifa.lap = 1'b1;
        step(1);
        ifa.lap = 1'b0;
        step(1);
        chk("lap_out",   ifa.lap_out, 24'h000501);
        chk("lap_valid", {23'd0, ifa.lap_valid}, 24'h1);
        ifa.start_stop = 1'b1; ifa.clear = 1'b1; ifa.lap = 1'b1;
        step(1);
        ifa.start_stop = 1'b0; ifa.clear = 1'b0; ifa.lap = 1'b0;
        step(1);
        chk("clr_time",  ifa.time_out, 24'h000000);
        chk("clr_flags", flags(), 24'h0);

        // Lap coincident with a tick, then reset mid-run at 00:12:34.
        do_load(24'h001233);
        pulse_start();
        step(3);
        ifa.lap = 1'b1;
        step(1);
        ifa.lap = 1'b0;
        step(1);
        chk("lap_tick_out",  ifa.lap_out,  24'h001233);
        chk("lap_tick_time", ifa.time_out, 24'h001234);
        chk("lap_tick_flg",  flags(), 24'h8 | 24'h4);
        rstn = 1'b0;
        #1;
        chk("async_rst_time", ifa.time_out, 24'h0);
        step(1);
        chk("rst2_lap",   ifa.lap_out, 24'h0);
        chk("rst2_flags", flags(), 24'h0);
        rstn = 1'b1;
        step(2);
        chk("post_rst_time",  ifa.time_out, 24'h0);
        chk("post_rst_flags", flags(), 24'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lap_timer.md
LAP_TIMER -- requirements
Module: lap_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1: clk cycles per count tick; legal range 1..2^20.
REQ-002 The block SHALL have parameter HR_MAX, default 99: maximum hour value; legal values 23 or 99.
REQ-003 Port clk, input, 1 bit: clock; all logic SHALL be on the rising edge.
REQ-004 Port rstn, input, 1 bit: reset; asynchronous, active-low.
REQ-005 Port start_stop, input, 1 bit: level input; only its rising edge SHALL have effect (toggle run).
REQ-006 Port clear, input, 1 bit: level input; only its rising edge SHALL have effect (zero the time, stop the timer).
REQ-007 Port lap, input, 1 bit: level input; only its rising edge SHALL have effect (capture a split).
REQ-008 Port dir, input, 1 bit: 0 = count up, 1 = count down; SHALL be sampled only in STOP.
REQ-009 Port load, input, 1 bit: single-cycle load strobe.
REQ-010 Port load_val, input, 24 bits: BCD value {hr_h, hr_l, min_h, min_l, sec_h, sec_l}.
REQ-011 Port time_out, output, 24 bits: current BCD time, same packing as load_val.
REQ-012 Port lap_out, output, 24 bits: last captured BCD time.
REQ-013 Port lap_valid, output, 1 bit: high when lap_out holds a capture.
REQ-014 Port running, output, 1 bit: high in RUN.
REQ-015 Port expired, output, 1 bit: high in DONE.
REQ-016 Port wrap, output, 1 bit: one-cycle pulse when an up-count rolls over.

Function
REQ-017 Edge detection: start_stop, clear and lap SHALL each pass through a 2-flop shift; edge = ~q[1] & q[0].
REQ-018 Input latency: an input first sampled high at edge k SHALL take effect in state and outputs at edge k+1.
REQ-019 The state machine SHALL have states STOP, RUN and DONE.
REQ-020 STOP->RUN on start edge, except when dir_latched=1 and time==000000, in which case the edge is ignored.
REQ-021 RUN->STOP on start edge; DONE->STOP on start edge.
REQ-022 RUN->DONE when a down tick reaches 000000.
REQ-023 dir_latched SHALL be captured from dir on the STOP->RUN transition.
REQ-024 Clear edge in any state SHALL set time to 000000, state to STOP, prescaler to 0, and lap_valid to 0; clear SHALL have priority over start and lap edges in the same cycle.
REQ-025 Prescaler: a counter 0..TICK_DIV-1 SHALL advance only in RUN and hold its value in STOP and DONE.
REQ-026 A tick SHALL occur when the prescaler equals TICK_DIV-1 in RUN; the prescaler then returns to 0.
REQ-027 With TICK_DIV=1, every RUN cycle SHALL be a tick.
REQ-028 Up count: sec_l wraps at 9, sec_h at 5, min_l at 9, min_h at 5, with ripple carry; hours count 0..HR_MAX as two BCD digits.
REQ-029 Up count at HR_MAX:59:59 on a tick -> 00:00:00, with wrap=1 for one cycle; state remains RUN.
REQ-030 Down count: decrement with BCD borrow (00 sec -> 59, 00 min -> 59); at 00:00:01 on a tick -> 00:00:00 and go to DONE.
REQ-031 load SHALL be accepted only in STOP and DONE, and only if all digits are valid BCD, min/sec tens <= 5, and hours <= HR_MAX.
REQ-032 An accepted load SHALL set time_out to load_val at the next edge, zero the prescaler, and force state to STOP.
REQ-033 An invalid load, or a load in RUN, SHALL be ignored.
REQ-034 Clear edge SHALL take priority over load.
REQ-035 Lap edge (not blocked by clear) SHALL copy time_out into lap_out at edge k+1 and set lap_valid.
REQ-036 If a tick and a lap edge coincide, lap_out SHALL take the pre-tick value.
REQ-037 running = (state==RUN); expired = (state==DONE); both outputs SHALL be registered-state decodes.

Reset
REQ-038 rstn low SHALL asynchronously set time_out=0, lap_out=0, lap_valid=0, wrap=0, state=STOP, prescaler=0, edge flops=0, and dir_latched=0.
REQ-039 Reset asserted mid-RUN SHALL discard the count with no tick; release SHALL be synchronous to clk.

Structure
REQ-040 Shared package lap_timer_pkg SHALL hold: state encodings (STOP=2'd0, RUN=2'd1, DONE=2'd2), BCD digit width (4), the packed time width (24), and the digit-limit constants 5 and 9.
REQ-041 Sub-module bcd_digit SHALL provide one up/down BCD digit with parameter MAX, synchronous load/clear, en, dir, and carry/borrow out; six instances SHALL be used.
REQ-042 Hour wrap SHALL be handled at top level because the limit spans two digits.

Verification
REQ-043 TICK_DIV=4, up count: start, run 40 cycles -> time_out=000010, running=1.
REQ-044 HR_MAX=23: load 235959, start, one tick -> time_out=000000, wrap pulse of exactly 1 cycle.
REQ-045 dir=1: load 000002, start -> after 2 ticks time_out=000000, expired=1; a further start edge -> STOP; another start edge with time 0 and dir=1 -> stays STOP.
REQ-046 Load 006000 (invalid) in STOP -> time_out unchanged; load 123456 during RUN -> ignored.
REQ-047 Clear, start and lap rising in the same cycle during RUN -> time_out=000000, STOP, lap_valid=0.
REQ-048 rstn low for 1 cycle mid-RUN at 001234 -> all outputs 0, STOP; a lap edge coincident with a tick captures the pre-tick value.
